// File: rtl/uart_link_sched_if.sv
// Avalon-MM bundle between uart_link_sched (master) and the UART core
// register port (slave).
//   avm_address     5-bit byte address (master to slave)
//   avm_read        read strobe (master to slave)
//   avm_write       write strobe (master to slave)
//   avm_writedata   32-bit write data (master to slave)
//   avm_readdata    32-bit read data, valid while waitrequest is low (slave to master)
//   avm_waitrequest slave stall (slave to master)
interface uart_link_sched_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/uart_link_sched.sv
// uart_link_sched: sole Avalon-MM master of the UART core register port.
// Polls STATUS, drains RX bytes into 24-bit RGB pixels (first byte in
// [23:16]) and writes queued TX bytes from a single-byte holding register.
// RX and TX that are ready in the same poll are served round-robin.
// Ports:
//   avm_clk, avm_rst_n   clock, asynchronous active-low reset
//   avm                  Avalon-MM master bundle (all outputs registered)
//   i_rx_en              service RX when STATUS reports data
//   i_rx_flush           discard a partially assembled pixel
//   i_tx_data/i_tx_valid byte offered for transmit
//   o_tx_ready           holding register empty (registered)
//   o_pix_data/o_pix_valid  assembled pixel and its one-cycle pulse
module uart_link_sched (
    input  logic                     avm_clk,
    input  logic                     avm_rst_n,
    uart_link_sched_if.master        avm,
    input  logic                     i_rx_en,
    input  logic                     i_rx_flush,
    input  logic [7:0]               i_tx_data,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    output logic [23:0]              o_pix_data,
    output logic                     o_pix_valid
);
    localparam logic [4:0] RX_ADDR     = 5'd0;
    localparam logic [4:0] TX_ADDR     = 5'd4;
    localparam logic [4:0] STATUS_ADDR = 5'd8;
    localparam int         TX_OK_BIT   = 6;
    localparam int         RX_OK_BIT   = 7;

    typedef enum logic [1:0] {S_GAP, S_POLL, S_RX, S_TX} state_t;

    state_t      state_r;
    state_t      next_r;        // state entered when the current gap ends
    state_t      poll_next_s;
    logic [1:0]  byte_cnt_r;
    logic [23:0] pix_acc_r;
    logic [23:0] rx_merged_s;
    logic [7:0]  tx_hold_r;
    logic        tx_full_r;
    logic        prio_rx_r;     // 1 = RX wins the next tie
    logic        done_s;
    logic        rx_ok_s;
    logic        tx_ok_s;
    logic        unused_rd_s;

    assign done_s      = ~avm.avm_waitrequest;
    assign rx_ok_s     = avm.avm_readdata[RX_OK_BIT] & i_rx_en;
    assign tx_ok_s     = avm.avm_readdata[TX_OK_BIT] & tx_full_r;
    assign unused_rd_s = ^avm.avm_readdata[31:8];

    // Choose the service that follows a completed STATUS poll.
    always_comb begin
        poll_next_s = S_POLL;
        if (rx_ok_s && tx_ok_s) begin
            if (prio_rx_r) begin
                poll_next_s = S_RX;
            end else begin
                poll_next_s = S_TX;
            end
        end else if (rx_ok_s) begin
            poll_next_s = S_RX;
        end else if (tx_ok_s) begin
            poll_next_s = S_TX;
        end else begin
            poll_next_s = S_POLL;
        end
    end

    // Drop the incoming RX byte into the slot selected by byte_cnt.
    always_comb begin
        rx_merged_s = pix_acc_r;
        case (byte_cnt_r)
            2'd0:    rx_merged_s[23:16] = avm.avm_readdata[7:0];
            2'd1:    rx_merged_s[15:8]  = avm.avm_readdata[7:0];
            2'd2:    rx_merged_s[7:0]   = avm.avm_readdata[7:0];
            default: rx_merged_s        = pix_acc_r;
        endcase
    end

    // Scheduler FSM, TX holding register and pixel assembly.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state_r           <= S_GAP;
            next_r            <= S_POLL;
            avm.avm_address   <= STATUS_ADDR;
            avm.avm_read      <= 1'b0;
            avm.avm_write     <= 1'b0;
            avm.avm_writedata <= 32'd0;
            byte_cnt_r        <= 2'd0;
            pix_acc_r         <= 24'd0;
            tx_hold_r         <= 8'd0;
            tx_full_r         <= 1'b0;
            prio_rx_r         <= 1'b1;
            o_tx_ready        <= 1'b1;
            o_pix_data        <= 24'd0;
            o_pix_valid       <= 1'b0;
        end else begin
            o_pix_valid <= 1'b0;
            // A load can never collide with the TX completion: one needs
            // tx_full low, the other needs it high.
            if (i_tx_valid && o_tx_ready) begin
                tx_hold_r  <= i_tx_data;
                tx_full_r  <= 1'b1;
                o_tx_ready <= 1'b0;
            end
            if (i_rx_flush) begin
                byte_cnt_r <= 2'd0;
            end
            case (state_r)
                S_GAP: begin
                    state_r <= next_r;
                    case (next_r)
                        S_RX: begin
                            avm.avm_address <= RX_ADDR;
                            avm.avm_read    <= 1'b1;
                        end
                        S_TX: begin
                            avm.avm_address   <= TX_ADDR;
                            avm.avm_write     <= 1'b1;
                            avm.avm_writedata <= {24'd0, tx_hold_r};
                        end
                        default: begin
                            state_r         <= S_POLL;
                            avm.avm_address <= STATUS_ADDR;
                            avm.avm_read    <= 1'b1;
                        end
                    endcase
                end
                S_POLL: begin
                    if (done_s) begin
                        avm.avm_read <= 1'b0;
                        state_r      <= S_GAP;
                        next_r       <= poll_next_s;
                    end
                end
                S_RX: begin
                    if (done_s) begin
                        avm.avm_read <= 1'b0;
                        state_r      <= S_GAP;
                        next_r       <= S_POLL;
                        prio_rx_r    <= 1'b0;
                        // A coincident flush discards the byte just read.
                        if (!i_rx_flush) begin
                            pix_acc_r <= rx_merged_s;
                            if (byte_cnt_r == 2'd2) begin
                                byte_cnt_r  <= 2'd0;
                                o_pix_data  <= rx_merged_s;
                                o_pix_valid <= 1'b1;
                            end else begin
                                byte_cnt_r <= byte_cnt_r + 2'd1;
                            end
                        end
                    end
                end
                S_TX: begin
                    if (done_s) begin
                        avm.avm_write     <= 1'b0;
                        avm.avm_writedata <= 32'd0;
                        tx_full_r         <= 1'b0;
                        o_tx_ready        <= 1'b1;
                        prio_rx_r         <= 1'b1;
                        state_r           <= S_GAP;
                        next_r            <= S_POLL;
                    end
                end
                default: begin
                    avm.avm_read  <= 1'b0;
                    avm.avm_write <= 1'b0;
                    state_r       <= S_GAP;
                    next_r        <= S_POLL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_link_sched.sv
// Self-checking bench for uart_link_sched: a UART register-port slave model
// plus a transaction-level reference (expected service sequence, pixel
// assembly, holding-register occupancy) evaluated once per cycle.
module tb_uart_link_sched;
    localparam int K_POLL = 0;
    localparam int K_RX   = 1;
    localparam int K_TX   = 2;

    logic        avm_clk = 1'b0;
    logic        avm_rst_n = 1'b0;
    logic        i_rx_en = 1'b0;
    logic        i_rx_flush = 1'b0;
    logic [7:0]  i_tx_data = 8'd0;
    logic        i_tx_valid = 1'b0;
    logic        o_tx_ready;
    logic [23:0] o_pix_data;
    logic        o_pix_valid;

    uart_link_sched_if bus ();

    uart_link_sched dut (
        .avm_clk     (avm_clk),
        .avm_rst_n   (avm_rst_n),
        .avm         (bus),
        .i_rx_en     (i_rx_en),
        .i_rx_flush  (i_rx_flush),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .o_tx_ready  (o_tx_ready),
        .o_pix_data  (o_pix_data),
        .o_pix_valid (o_pix_valid)
    );

    always #5 avm_clk = ~avm_clk;

    int n_cmp = 0;
    int n_err = 0;

    // scenario controls
    bit          rand_ctl;
    bit          status_rand;
    logic [31:0] status_val;
    int          stall_mode;       // 0 none, 1 random, 2 five-cycle stall on RX reads
    bit          d_rx_en, d_flush, d_tx_valid;
    logic [7:0]  d_tx_data;
    logic [7:0]  rx_q[$];

    // reference model state
    bit          tx_full_m, prio_m, pend_pulse, gap_phase, prev_stall;
    int          cnt_m, exp_kind, stall_left;
    logic [7:0]  part_m [3];
    logic [7:0]  held_m;
    logic [23:0] exp_pix;
    logic [4:0]  snap_addr;
    logic        snap_rd, snap_wr;
    logic [31:0] snap_wd, last_wdata;
    int          pix_seen, rx_done, tx_done;
    int          svc_q[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        avm_rst_n = 1'b0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'd0;
        i_rx_en = 1'b0; i_rx_flush = 1'b0; i_tx_valid = 1'b0; i_tx_data = 8'd0;
        d_rx_en = 1'b1; d_flush = 1'b0; d_tx_valid = 1'b0; d_tx_data = 8'd0;
        rand_ctl = 1'b0; status_rand = 1'b0; status_val = 32'd0; stall_mode = 0;
        rx_q.delete(); svc_q.delete();
        pix_seen = 0; rx_done = 0; tx_done = 0;
        repeat (3) @(negedge avm_clk);
        check_eq("rst_addr", 32'(bus.avm_address), 32'd8);
        check_eq("rst_read", 32'(bus.avm_read), 32'd0);
        check_eq("rst_write", 32'(bus.avm_write), 32'd0);
        check_eq("rst_wdata", bus.avm_writedata, 32'd0);
        check_eq("rst_tx_ready", 32'(o_tx_ready), 32'd1);
        check_eq("rst_pix_data", 32'(o_pix_data), 32'd0);
        check_eq("rst_pix_valid", 32'(o_pix_valid), 32'd0);
        avm_rst_n = 1'b1;
        tx_full_m = 1'b0; prio_m = 1'b1; cnt_m = 0; pend_pulse = 1'b0;
        gap_phase = 1'b0; exp_kind = K_POLL; prev_stall = 1'b0; stall_left = 0;
    endtask

    // One clock: check what the last edge produced, then drive the next edge.
    task automatic cycle();
        logic        strobe, in_txn, wait_s, tx_rdy_m, rx_ok, tx_ok;
        logic [7:0]  rx_byte;
        logic [4:0]  e_addr;
        logic        e_rd;
        @(negedge avm_clk);
        check_eq("tx_ready", 32'(o_tx_ready), 32'(!tx_full_m));
        if (pend_pulse || o_pix_valid) begin
            check_eq("pix_valid", 32'(o_pix_valid), 32'(pend_pulse));
            if (pend_pulse) check_eq("pix_data", 32'(o_pix_data), 32'(exp_pix));
            if (o_pix_valid) pix_seen++;
        end
        pend_pulse = 1'b0;
        check_eq("rd_wr_excl", 32'(bus.avm_read & bus.avm_write), 32'd0);
        if (prev_stall) begin
            check_eq("hold_addr", 32'(bus.avm_address), 32'(snap_addr));
            check_eq("hold_strobe", 32'({bus.avm_read, bus.avm_write}), 32'({snap_rd, snap_wr}));
            check_eq("hold_wdata", bus.avm_writedata, snap_wd);
        end
        strobe = bus.avm_read | bus.avm_write;
        in_txn = 1'b0;
        if (gap_phase) begin
            check_eq("gap", 32'(strobe), 32'd0);
            gap_phase = 1'b0;
        end else begin
            check_eq("strobe_on", 32'(strobe), 32'd1);
            in_txn = 1'b1;
            case (exp_kind)
                K_RX:    begin e_addr = 5'd0; e_rd = 1'b1; end
                K_TX:    begin e_addr = 5'd4; e_rd = 1'b0; end
                default: begin e_addr = 5'd8; e_rd = 1'b1; end
            endcase
            check_eq("txn_addr", 32'(bus.avm_address), 32'(e_addr));
            check_eq("txn_kind", 32'({bus.avm_read, bus.avm_write}), 32'({e_rd, !e_rd}));
        end

        tx_rdy_m = !tx_full_m;
        if (rand_ctl) begin
            i_rx_en    = ($urandom_range(0, 7) != 0);
            i_rx_flush = ($urandom_range(0, 40) == 0);
            i_tx_valid = 1'($urandom_range(0, 1));
            i_tx_data  = 8'($urandom);
        end else begin
            i_rx_en = d_rx_en; i_rx_flush = d_flush;
            i_tx_valid = d_tx_valid; i_tx_data = d_tx_data;
        end
        if (i_rx_flush) cnt_m = 0;
        wait_s = 1'b0;
        bus.avm_readdata = $urandom;
        if (in_txn) begin
            if (!prev_stall) begin
                if (stall_mode == 1 && $urandom_range(0, 2) == 0) stall_left = $urandom_range(1, 4);
                else if (stall_mode == 2 && exp_kind == K_RX) stall_left = 5;
                else stall_left = 0;
            end
            wait_s = (stall_left > 0);
            if (wait_s) stall_left--;
            if (!wait_s) begin
                gap_phase = 1'b1;
                case (exp_kind)
                    K_RX: begin
                        rx_byte = (rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom);
                        bus.avm_readdata = {24'($urandom), rx_byte};
                        rx_done++; svc_q.push_back(K_RX);
                        if (!i_rx_flush) begin
                            part_m[cnt_m] = rx_byte;
                            if (cnt_m == 2) begin
                                exp_pix = {part_m[0], part_m[1], part_m[2]};
                                pend_pulse = 1'b1;
                                cnt_m = 0;
                            end else begin
                                cnt_m++;
                            end
                        end
                        prio_m = 1'b0; exp_kind = K_POLL;
                    end
                    K_TX: begin
                        check_eq("tx_wdata", bus.avm_writedata, {24'd0, held_m});
                        last_wdata = bus.avm_writedata;
                        tx_done++; svc_q.push_back(K_TX);
                        tx_full_m = 1'b0; prio_m = 1'b1; exp_kind = K_POLL;
                    end
                    default: begin
                        bus.avm_readdata = status_rand ? $urandom : status_val;
                        rx_ok = bus.avm_readdata[7] & i_rx_en;
                        tx_ok = bus.avm_readdata[6] & tx_full_m;
                        if (rx_ok && tx_ok) exp_kind = prio_m ? K_RX : K_TX;
                        else if (rx_ok) exp_kind = K_RX;
                        else if (tx_ok) exp_kind = K_TX;
                        else exp_kind = K_POLL;
                    end
                endcase
            end
            snap_addr = bus.avm_address; snap_rd = bus.avm_read;
            snap_wr = bus.avm_write; snap_wd = bus.avm_writedata;
        end
        prev_stall = wait_s;
        if (i_tx_valid && tx_rdy_m) begin
            tx_full_m = 1'b1;
            held_m = i_tx_data;
        end
        bus.avm_waitrequest = wait_s;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pix(input int n, input int budget);
        for (int i = 0; i < budget && pix_seen < n; i++) cycle();
        check_eq("pix_count", 32'(pix_seen), 32'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle: STATUS reports nothing
        do_reset();
        run(20);
        check_eq("idle_rx", 32'(rx_done), 32'd0);
        check_eq("idle_tx", 32'(tx_done), 32'd0);
        check_eq("idle_pix", 32'(pix_seen), 32'd0);

        // one pixel from three RX bytes
        do_reset();
        status_val = 32'h80;
        rx_q = '{8'h12, 8'h34, 8'h56};
        wait_pix(1, 40);
        status_val = 32'h00;
        run(8);
        check_eq("pix1_count", 32'(pix_seen), 32'd1);
        check_eq("pix1_data", 32'(o_pix_data), 32'h123456);

        // single TX byte
        do_reset();
        status_val = 32'h40;
        d_tx_valid = 1'b1; d_tx_data = 8'hA5;
        for (int i = 0; i < 10 && !tx_full_m; i++) cycle();
        d_tx_valid = 1'b0;
        for (int i = 0; i < 20 && tx_done == 0; i++) cycle();
        run(3);
        check_eq("tx1_count", 32'(tx_done), 32'd1);
        check_eq("tx1_wdata", last_wdata, 32'h000000A5);

        // RX and TX both ready: round-robin
        do_reset();
        status_val = 32'hC0;
        d_tx_valid = 1'b1; d_tx_data = 8'h3C;
        run(60);
        d_tx_valid = 1'b0;
        check_eq("rr_len", 32'(svc_q.size() >= 4), 32'd1);
        if (svc_q.size() >= 4) begin
            check_eq("rr_0", 32'(svc_q[0]), 32'(K_RX));
            check_eq("rr_1", 32'(svc_q[1]), 32'(K_TX));
            check_eq("rr_2", 32'(svc_q[2]), 32'(K_RX));
            check_eq("rr_3", 32'(svc_q[3]), 32'(K_TX));
        end
        check_eq("rr_balance", 32'((rx_done - tx_done <= 1) && (tx_done - rx_done <= 1)), 32'd1);

        // five-cycle stall on every RX read
        do_reset();
        status_val = 32'h80; stall_mode = 2;
        rx_q = '{8'hAB, 8'hCD, 8'hEF};
        wait_pix(1, 80);
        check_eq("stall_pix", 32'(o_pix_data), 32'hABCDEF);

        // flush after two bytes
        do_reset();
        status_val = 32'h80;
        rx_q = '{8'hAA, 8'hBB};
        for (int i = 0; i < 30 && rx_done < 2; i++) cycle();
        status_val = 32'h00;
        run(6);
        d_flush = 1'b1; cycle(); d_flush = 1'b0;
        rx_q = '{8'h01, 8'h02, 8'h03};
        status_val = 32'h80;
        wait_pix(1, 40);
        check_eq("flush_pix", 32'(o_pix_data), 32'h010203);

        // reset in the middle of a write
        do_reset();
        status_val = 32'h40;
        d_tx_valid = 1'b1; d_tx_data = 8'h77;
        for (int i = 0; i < 10 && !tx_full_m; i++) cycle();
        d_tx_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.avm_write; i++) cycle();
        check_eq("midwr_seen", 32'(bus.avm_write), 32'd1);
        #2 avm_rst_n = 1'b0;
        #1;
        check_eq("midwr_write", 32'(bus.avm_write), 32'd0);
        check_eq("midwr_tx_ready", 32'(o_tx_ready), 32'd1);
        do_reset();

        // random soak
        rand_ctl = 1'b1; status_rand = 1'b1; stall_mode = 1;
        run(3000);
        check_eq("soak_progress", 32'(pix_seen > 0 && tx_done > 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
